// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for NUM_DIGITS common-anode seven-segment
// digits. It has a double-buffered shadow register, per-digit blink and
// decimal point, and a blanking guard at the start of every digit dwell.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   en          1 = display on; 0 = all anodes off while the counters keep running
//   load        one-cycle strobe that latches codes / blink_mask / dp_mask
//   codes       5-bit glyph code per digit; digit i = codes[5i+4:5i], digit 0 rightmost
//   blink_mask  1 = digit blanks during the blink-off phase
//   dp_mask     1 = decimal point lit
//   seg_out     active-low segments; [6:0] = g..a, [7] = dp (registered)
//   seg_en      active-low anode enables, at most one low (registered)
module seg_scan #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned GUARD      = 1000,
    parameter int unsigned BLINK_DIV  = 25
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [5*NUM_DIGITS-1:0]   codes,
    input  logic [NUM_DIGITS-1:0]     blink_mask,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     seg_en
);

    localparam int unsigned CODE_W  = 5;
    localparam int unsigned GLYPH_W = 7;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLK_W   = BLINK_DIV + 1;

    localparam logic [CODE_W-1:0] CODE_BLANK = 5'h0F;
    localparam logic [SEG_W-1:0]  SEG_OFF    = 8'hFF;

    // Shadow register contents
    logic [NUM_DIGITS-1:0][CODE_W-1:0] code_q;
    logic [NUM_DIGITS-1:0]             blink_q;
    logic [NUM_DIGITS-1:0]             dp_q;

    // Scan and blink counters
    logic                  run;
    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      digit_idx;
    logic [BLK_W-1:0]      blink_cnt;

    // Next-output signals
    logic [CODE_W-1:0]     sel_code;
    logic [GLYPH_W-1:0]    glyph;
    logic                  in_guard;
    logic                  blink_off;
    logic [SEG_W-1:0]      seg_out_nxt;
    logic [NUM_DIGITS-1:0] seg_en_nxt;

    // Glyph ROM: 5-bit code to active-low {g,f,e,d,c,b,a}
    function automatic logic [GLYPH_W-1:0] glyph_rom(input logic [CODE_W-1:0] code);
        logic [GLYPH_W-1:0] g;
        g = 7'b1111111;
        case (code)
            5'h00: g = 7'b1000000;
            5'h01: g = 7'b1111001;
            5'h02: g = 7'b0100100;
            5'h03: g = 7'b0110000;
            5'h04: g = 7'b0011001;
            5'h05: g = 7'b0010010;
            5'h06: g = 7'b0000010;
            5'h07: g = 7'b1111000;
            5'h08: g = 7'b0000000;
            5'h09: g = 7'b0010000;
            5'h0A: g = 7'b0001100;  // P
            5'h0B: g = 7'b1000111;  // L
            5'h0C: g = 7'b0010010;  // S
            5'h0D: g = 7'b1000110;  // C
            5'h0E: g = 7'b1110001;  // J
            5'h0F: g = 7'b1111111;  // blank
            5'h10: g = 7'b1000001;  // U
            5'h11: g = 7'b0001000;  // A
            5'h12: g = 7'b0100011;  // o
            5'h13: g = 7'b0011100;  // upper o
            5'h14: g = 7'b0000011;  // b
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    // Shadow register: the display only sees new data on a load strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= {NUM_DIGITS{CODE_BLANK}};
            blink_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            code_q  <= codes;
            blink_q <= blink_mask;
            dp_q    <= dp_mask;
        end
    end

    // Scan prescaler, digit index and blink counter. The counters hold for
    // the first clock after reset, so the output at edge k reflects count k-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            run       <= 1'b0;
            div_cnt   <= '0;
            digit_idx <= '0;
            blink_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                blink_cnt <= blink_cnt + BLK_W'(1);
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_cnt <= '0;
                    if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                        digit_idx <= '0;
                    end else begin
                        digit_idx <= digit_idx + IDX_W'(1);
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

    // Segment and anode selection for the currently scanned digit
    always_comb begin
        seg_out_nxt = SEG_OFF;
        seg_en_nxt  = '1;
        sel_code    = code_q[digit_idx];
        glyph       = glyph_rom(sel_code);
        in_guard    = (div_cnt < DIV_W'(GUARD));
        // Blinked digits keep the anode on; only the segments go dark
        blink_off   = blink_cnt[BLINK_DIV] & blink_q[digit_idx];
        if (en && !in_guard) begin
            seg_en_nxt[digit_idx] = 1'b0;
            if (!blink_off) begin
                seg_out_nxt = {~dp_q[digit_idx], glyph};
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out <= SEG_OFF;
            seg_en  <= '1;
        end else begin
            seg_out <= seg_out_nxt;
            seg_en  <= seg_en_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed bench for seg_scan (4 digits, 8-clock dwell, 2-clock
// guard, 16-clock blink phase). Expected outputs come from an edge-count model
// and go through a queue to the comparison point.
module tb_seg_scan;

    localparam int unsigned NDIG  = 4;
    localparam int unsigned SDIV  = 8;
    localparam int unsigned GRD   = 2;
    localparam int unsigned BDIV  = 4;

    logic               clk;
    logic               rst;
    logic               en;
    logic               load;
    logic [5*NDIG-1:0]  codes;
    logic [NDIG-1:0]    blink_mask;
    logic [NDIG-1:0]    dp_mask;
    logic [7:0]         seg_out;
    logic [NDIG-1:0]    seg_en;

    seg_scan #(
        .NUM_DIGITS (NDIG),
        .SCAN_DIV   (SDIV),
        .GUARD      (GRD),
        .BLINK_DIV  (BDIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .codes      (codes),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .seg_out    (seg_out),
        .seg_en     (seg_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference glyph table, {g..a} active-low
    logic [6:0] rom [0:31] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h0C, 7'h47, 7'h12, 7'h46, 7'h71, 7'h7F,
        7'h41, 7'h08, 7'h23, 7'h1C, 7'h03, 7'h7F, 7'h7F, 7'h7F,
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    int unsigned checks = 0;
    int unsigned passes = 0;

    // Model state: edges since reset release plus the shadow contents
    int unsigned k = 0;
    logic [4:0]  m_code [0:NDIG-1];
    logic [NDIG-1:0] m_blink;
    logic [NDIG-1:0] m_dp;
    logic [11:0] exp_q [$];

    int unsigned last_k;
    int unsigned last_idx;
    logic        last_vis;
    logic [4:0]  last_code;
    logic        found;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s edge=%0d observed=%h expected=%h", tag, last_k, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NDIG; i++) m_code[i] = 5'h0F;
        m_blink = '0;
        m_dp    = '0;
    endtask

    // One clock: predict, push, clock, pop and compare
    task automatic step();
        logic [3:0]  e_en;
        logic [7:0]  e_out;
        logic [11:0] e;
        int unsigned c;
        int unsigned dv;
        int unsigned ix;
        logic        ph;
        c     = (k == 0) ? 0 : k - 1;
        dv    = c % SDIV;
        ix    = (c / SDIV) % NDIG;
        ph    = ((c >> BDIV) & 1) == 1;
        e_en  = 4'hF;
        e_out = 8'hFF;
        last_vis = 1'b0;
        if (!rst && en && dv >= GRD) begin
            e_en[ix] = 1'b0;
            last_vis = 1'b1;
            if (!(ph && m_blink[ix])) e_out = {~m_dp[ix], rom[m_code[ix]]};
        end
        exp_q.push_back({e_en, e_out});
        last_k    = k;
        last_idx  = ix;
        last_code = m_code[ix];
        @(posedge clk);
        if (rst) begin
            k = 0;
            model_reset();
        end else begin
            k++;
            if (load) begin
                for (int i = 0; i < NDIG; i++) m_code[i] = codes[5*i +: 5];
                m_blink = blink_mask;
                m_dp    = dp_mask;
            end
        end
        #1;
        e = exp_q.pop_front();
        check("seg_en", {4'h0, seg_en}, {4'h0, e[11:8]});
        check("seg_out", seg_out, e[7:0]);
    endtask

    initial begin
        model_reset();
        rst        = 1'b1;
        en         = 1'b1;
        load       = 1'b0;
        codes      = {NDIG{5'h0F}};
        blink_mask = '0;
        dp_mask    = '0;
        repeat (3) step();
        check("reset_seg_en", {4'h0, seg_en}, 8'h0F);
        check("reset_seg_out", seg_out, 8'hFF);

        // Scan order and first-digit latency
        rst   = 1'b0;
        load  = 1'b1;
        codes = {5'd3, 5'd2, 5'd1, 5'd0};
        step();
        load = 1'b0;
        repeat (64) begin
            step();
            if (last_k == GRD) check("guard_before_d0", {4'h0, seg_en}, 8'h0F);
            if (last_k == GRD + 1) begin
                check("first_d0_en", {4'h0, seg_en}, 8'h0E);
                check("first_d0_seg", seg_out, 8'hC0);
            end
            if (last_k == SDIV + GRD + 1) check("first_d1_en", {4'h0, seg_en}, 8'h0D);
            if (last_k == 3*SDIV + GRD + 1) begin
                check("d3_en", {4'h0, seg_en}, 8'h07);
                check("d3_seg", seg_out, 8'hB0);
            end
        end

        // Glyph sweep on digit 0
        for (int cd = 0; cd < 32; cd++) begin
            codes = {5'h0F, 5'h0F, 5'h0F, 5'(cd)};
            load  = 1'b1;
            step();
            load  = 1'b0;
            repeat (NDIG*SDIV) begin
                step();
                if (last_vis && last_idx == 0 && last_code >= 5'h15)
                    check("unused_code_blank", {1'b0, seg_out[6:0]}, 8'h7F);
            end
        end

        // Double buffer: input changes without load are invisible
        codes = {5'd4, 5'd5, 5'd6, 5'd7};
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (NDIG*SDIV) step();
        codes = {5'h11, 5'h12, 5'h13, 5'h14};
        repeat (NDIG*SDIV) step();
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (NDIG*SDIV) step();

        // Blink on digit 0, decimal point on digit 1
        codes      = {5'd3, 5'd2, 5'd1, 5'd0};
        blink_mask = 4'b0001;
        dp_mask    = 4'b0010;
        load       = 1'b1;
        step();
        load = 1'b0;
        repeat (3*NDIG*SDIV) begin
            step();
            if (last_vis && last_idx == 1) check("dp_d1", {7'h0, seg_out[7]}, 8'h00);
            if (last_vis && last_idx == 0) check("blink_anode_d0", {4'h0, seg_en}, 8'h0E);
        end

        // Display disable keeps the scan running underneath
        en = 1'b0;
        repeat (20) begin
            step();
            check("en_off_seg_en", {4'h0, seg_en}, 8'h0F);
        end
        en = 1'b1;
        repeat (NDIG*SDIV) step();

        // Mid-scan reset while digit 2 is shown, with a load that must be ignored
        found = 1'b0;
        for (int n = 0; n < 2*NDIG*SDIV && !found; n++) begin
            step();
            if (last_vis && last_idx == 2) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $error("FAIL digit2_timeout observed=none expected=digit2");
        end
        rst   = 1'b1;
        load  = 1'b1;
        codes = {5'd8, 5'd8, 5'd8, 5'd8};
        step();
        check("midreset_seg_en", {4'h0, seg_en}, 8'h0F);
        check("midreset_seg_out", seg_out, 8'hFF);
        rst  = 1'b0;
        load = 1'b0;
        repeat (12) begin
            step();
            if (last_k == GRD + 1) begin
                check("after_reset_d0", {4'h0, seg_en}, 8'h0E);
                check("load_with_rst_ignored", seg_out, 8'hFF);
            end
        end
        codes = {5'd3, 5'd2, 5'd1, 5'd0};
        load  = 1'b1;
        step();
        load  = 1'b0;
        repeat (NDIG*SDIV) step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed driver for a bank of common-anode seven-segment digits. It extends the single-digit glyph decoder to `NUM_DIGITS` digits, scanned one at a time with a programmable dwell. It adds a double-buffered code register, per-digit blink and decimal point, and an anti-ghosting blanking guard. It sits between the answering-machine control logic (scores, channel numbers, status words) and the board's segment/anode pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned, 1..8.
- `SCAN_DIV`, 100000: clocks each digit stays selected (dwell), ≥ `GUARD`+2.
- `GUARD`, 1000: clocks at the start of each dwell with all anodes off, ≥ 1.
- `BLINK_DIV`, 25: blink phase toggles every 2^`BLINK_DIV` clocks.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  1 = display on; 0 = all anodes off, scanning continues.
- `load`  in  1  one-cycle strobe; latches `codes`, `blink_mask`, `dp_mask` into the shadow register.
- `codes`  in  5·`NUM_DIGITS`  glyph code per digit; digit i = `codes[5i+4:5i]`, and digit 0 is the rightmost.
- `blink_mask`  in  `NUM_DIGITS`  1 = digit blanks during the blink-off phase.
- `dp_mask`  in  `NUM_DIGITS`  1 = decimal point lit.
- `seg_out`  out  8  active-low; `[6:0]` = g,f,e,d,c,b,a and `[7]` = dp.
- `seg_en`  out  `NUM_DIGITS`  active-low anode enables, at most one low.

## Operation
- Glyph ROM: 5-bit code → {g..a}, active-low.
  - Digits: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Letters: 0A P:0001100, 0B L:1000111, 0C S:0010010, 0D C:1000110, 0E J:1110001.
  - 0F blank:1111111.
  - 10 U:1000001, 11 A:0001000, 12 o:0100011, 13 upper-o:0011100, 14 b:0000011.
  - 15..1F: blank.
- Shadow register:
  - `load`=1 copies all three inputs in the same clock.
  - Between loads the display ignores input changes, so there is no tearing.
- Prescaler `div_cnt` counts 0..`SCAN_DIV`-1 and then wraps.
  - At the wrap, `digit_idx` advances by 1. It wraps from `NUM_DIGITS`-1 to 0.
- Guard window:
  - While `div_cnt` < `GUARD`, `seg_en` is all 1s and `seg_out` is 8'hFF.
  - Otherwise `seg_en[digit_idx]`=0 and `seg_out` = {~dp_mask[idx], glyph(code[idx])}.
- Blink:
  - Free-running `blink_cnt` is `BLINK_DIV`+1 bits wide; its MSB is the phase (1 = off).
  - While the phase is off, digits with blink bit 1 output seg_out=8'hFF, but their anode stays enabled.
- `en`=0 forces `seg_en` to all 1s and `seg_out` to 8'hFF. The counters keep running.
- Reset:
  - `div_cnt`, `digit_idx` and `blink_cnt` go to 0.
  - The shadow register takes codes = all 0F (blank), and masks = 0.
  - `seg_en` = all 1s and `seg_out` = 8'hFF.

## Timing
- All outputs are registered. An output reflects the counter and shadow state of the previous clock, a fixed 1-cycle latency.
- `load` at edge N: the new glyph can appear at edge N+1, but only for the digit currently selected outside the guard window.
- First digit after reset:
  - `rst` is released before edge 0.
  - `seg_en[0]` goes low at edge `GUARD`+1.
  - Digit 1 is selected from edge `SCAN_DIV`+`GUARD`+1.
- Full refresh period = `NUM_DIGITS`·`SCAN_DIV` clocks.
- `rst` asserted mid-scan: outputs go blank at the next edge and the counters restart at 0. A `load` in the same cycle as `rst` is ignored.
- `NUM_DIGITS`=1: `digit_idx` stays 0. The guard still blanks the output for `GUARD` clocks in every dwell.
- `load` coincident with a digit advance: the new digit shows the new data.

## Test plan
1. Reset and blank-free scan. Parameters: NUM_DIGITS=4, SCAN_DIV=8, GUARD=2. Stimulus: reset, then `load` codes {3,2,1,0}. Required response:
   - `seg_en` cycles 1110→1101→1011→0111 every 8 clocks, with 1111 for 2 clocks before each step.
   - `seg_out` for digit 0 is 8'hC0, and for digit 3 it is 8'hB0.
2. Glyph sweep. Load each code 00..1F into digit 0. Check the `seg_out[6:0]` table value for every code; codes 15..1F must give 7'h7F.
3. Double buffer. Change `codes` without `load`: the output must stay unchanged for one full refresh. After `load`, the next dwell of that digit shows the new code.
4. Blink and dp. Parameters: BLINK_DIV=4, blink_mask=0001, dp_mask=0010. Required response:
   - Digit 0 alternates between its glyph and 8'hFF every 16 clocks, with its anode still low.
   - Digit 1 always shows `seg_out[7]`=0.
5. Enable and mid-scan reset.
   - `en`=0 for 20 clocks gives `seg_en`=1111 and `seg_out`=FF. After `en` returns to 1, the scan continues at the counter-predicted digit.
   - `rst` pulsed while digit 2 is shown gives outputs blank at the next edge and digit 0 shown first afterwards.
